// File: rtl/apb_cmd_pkg.sv
// Shared encodings for the APB command master: command opcodes and FSM states.
package apb_cmd_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_INCR  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS wait cycles; hit_o flags the TIMEOUT_CYC-th consecutive wait cycle.
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_W'(TIMEOUT_CYC))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/apb_cmd_master.sv
// Command-to-APB bridge: READ/WRITE/INCR commands become APB transfers with a held response.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_cmd_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic              pready_i,
  input  logic              pslverr_i,
  input  logic [DATA_W-1:0] prdata_i
);

  import apb_cmd_pkg::*;

  state_e            state_q, state_d;
  cmd_op_e           op_q, op_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              to_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q == ST_SETUP),
    .en_i  ((state_q == ST_ACCESS) && !pready_i),
    .hit_o (to_hit)
  );
`else
  // No timeout: ACCESS waits for pready_i indefinitely.
  assign to_hit = 1'b0 && (TIMEOUT_CYC >= 2);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NOP;
      cap_q       <= '0;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cap_q       <= cap_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cap_d       = cap_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_q && (cmd_op_i != OP_NOP)) begin
          state_d  = ST_SETUP;
          op_d     = cmd_op_e'(cmd_op_i);
          paddr_d  = cmd_addr_i;
          pwrite_d = (cmd_op_i == OP_WRITE);
          pwdata_d = (cmd_op_i == OP_WRITE) ? cmd_wdata_i : '0;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (pready_i) begin
          // INCR read phase loops back to SETUP as a write of the captured value + 1.
          if ((op_q == OP_INCR) && !pwrite_q && !pslverr_i) begin
            state_d  = ST_SETUP;
            pwrite_d = 1'b1;
            pwdata_d = prdata_i + DATA_W'(1);
            cap_d    = prdata_i;
          end else begin
            state_d   = ST_RESP;
            rsp_err_d = pslverr_i;
            if (pslverr_i) begin
              rsp_rdata_d = '0;
            end else if (op_q == OP_READ) begin
              rsp_rdata_d = prdata_i;
            end else if (op_q == OP_INCR) begin
              rsp_rdata_d = cap_q;
            end else begin
              rsp_rdata_d = '0;
            end
          end
        end else if (to_hit) begin
          state_d     = ST_RESP;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_d = (state_d == ST_IDLE);
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
    rsp_valid_d = (state_d == ST_RESP);
  end

  assign cmd_ready_o = cmd_ready_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
